if_fetch_ctrl: RTL and testbench

// - Sequencer for the IF stage: owns PC source selection, exception-vector select, fetch enable, flush and stall.
// - Sits between the ID/EX/CSR control logic and the IF stage, driving its pc_sel_mux / exc_sel / pc_set / flush / stall / pc_sel inputs.
// - Arbitrates simultaneous redirect requests by fixed priority. Sequences boot, debug entry/exit, WFI sleep and post-redirect flush.

---
 rtl/if_fetch_ctrl_pkg.sv | 44 ++++
 rtl/if_fetch_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types for the IF-stage fetch sequencer: PC/exception-vector selects,
// sequencer states and the redirect request priority classes.
package if_fetch_ctrl_pkg;

   localparam int unsigned BOOT_CNT_W  = 4;
   localparam int unsigned FLUSH_CNT_W = 3;

   typedef enum logic [2:0] {
      PC_BP,
      PC_NEXT,
      PC_EXC,
      PC_ERET,
      PC_DRET
   } pc_sel_e;

   typedef enum logic [1:0] {
      EXC_PC_EXC,
      EXC_PC_IRQ,
      EXC_PC_DBD,
      EXC_PC_DBG_EXC
   } exc_pc_sel_e;

   typedef enum logic [2:0] {
      FC_RESET,
      FC_BOOT,
      FC_FLUSH,
      FC_RUN,
      FC_SLEEP
   } fc_state_e;

   // Winning request class in FC_RUN, highest priority first.
   typedef enum logic [3:0] {
      REQ_NONE,
      REQ_DBG,
      REQ_EXC,
      REQ_IRQ,
      REQ_DRET,
      REQ_MRET,
      REQ_BRANCH,
      REQ_WFI,
      REQ_STALL
   } fc_req_e;

endpackage

// File: rtl/if_fetch_ctrl.sv
// IF-stage sequencer: boot, fixed-priority redirect arbitration, post-redirect
// flush, debug entry/exit and WFI sleep. Every output is a register.
module if_fetch_ctrl
   import if_fetch_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned BOOT_DELAY   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_enable_i,
   input  logic        stall_req_i,
   input  logic        branch_taken_i,
   input  logic        exc_req_i,
   input  logic        irq_req_i,
   input  logic        irq_en_i,
   input  logic        dbg_req_i,
   input  logic        mret_i,
   input  logic        dret_i,
   input  logic        wfi_i,
   output pc_sel_e     pc_sel_mux_o,
   output exc_pc_sel_e exc_sel_o,
   output logic        pc_sel_o,
   output logic        pc_set_o,
   output logic        flush_o,
   output logic        stall_o,
   output logic        debug_mode_o,
   output logic        sleeping_o
);

   fc_state_e               state_q, state_d;
   logic [BOOT_CNT_W-1:0]   boot_cnt_q, boot_cnt_d;
   logic [FLUSH_CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic                    debug_d;
   fc_req_e                 req;

   pc_sel_e                 pc_sel_mux_d;
   exc_pc_sel_e             exc_sel_d;
   logic                    pc_sel_d;
   logic                    pc_set_d;
   logic                    flush_d;
   logic                    stall_d;
   logic                    sleeping_d;
   logic                    redirect;

   // Fixed-priority request encoder; only consulted in FC_RUN.
   always_comb begin
      req = REQ_NONE;
      if (dbg_req_i && !debug_mode_o)                  req = REQ_DBG;
      else if (exc_req_i)                              req = REQ_EXC;
      else if (irq_req_i && irq_en_i && !debug_mode_o) req = REQ_IRQ;
      else if (dret_i && debug_mode_o)                 req = REQ_DRET;
      else if (mret_i)                                 req = REQ_MRET;
      else if (branch_taken_i)                         req = REQ_BRANCH;
      else if (wfi_i && !debug_mode_o)                 req = REQ_WFI;
      else if (stall_req_i)                            req = REQ_STALL;
   end

   // Next-state and next-output logic; outputs land one cycle after the request.
   always_comb begin
      state_d      = state_q;
      boot_cnt_d   = boot_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      debug_d      = debug_mode_o;
      pc_sel_mux_d = PC_NEXT;
      exc_sel_d    = EXC_PC_EXC;
      pc_sel_d     = 1'b0;
      pc_set_d     = 1'b0;
      flush_d      = 1'b0;
      stall_d      = 1'b0;
      sleeping_d   = 1'b0;
      redirect     = 1'b0;

      case (state_q)
         FC_RESET: begin
            if (boot_cnt_q == BOOT_CNT_W'(BOOT_DELAY)) begin
               if (fetch_enable_i) state_d = FC_BOOT;
            end else begin
               boot_cnt_d = boot_cnt_q + BOOT_CNT_W'(1);
            end
         end

         FC_BOOT: begin
            pc_sel_mux_d = PC_BP;
            redirect     = 1'b1;
         end

         FC_FLUSH: begin
            flush_d = 1'b1;
            if (flush_cnt_q <= FLUSH_CNT_W'(1)) state_d = FC_RUN;
            else flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
         end

         FC_RUN: begin
            pc_set_d = 1'b1;
            case (req)
               REQ_DBG: begin
                  pc_sel_mux_d = PC_EXC;
                  exc_sel_d    = EXC_PC_DBD;
                  debug_d      = 1'b1;
                  redirect     = 1'b1;
               end
               REQ_EXC: begin
                  pc_sel_mux_d = PC_EXC;
                  exc_sel_d    = debug_mode_o ? EXC_PC_DBG_EXC : EXC_PC_EXC;
                  redirect     = 1'b1;
               end
               REQ_IRQ: begin
                  pc_sel_mux_d = PC_EXC;
                  exc_sel_d    = EXC_PC_IRQ;
                  redirect     = 1'b1;
               end
               REQ_DRET: begin
                  pc_sel_mux_d = PC_DRET;
                  debug_d      = 1'b0;
                  redirect     = 1'b1;
               end
               REQ_MRET: begin
                  pc_sel_mux_d = PC_ERET;
                  redirect     = 1'b1;
               end
               REQ_BRANCH: begin
                  pc_sel_d = 1'b1;
                  redirect = 1'b1;
               end
               REQ_WFI: begin
                  pc_set_d   = 1'b0;
                  stall_d    = 1'b1;
                  sleeping_d = 1'b1;
                  state_d    = FC_SLEEP;
               end
               REQ_STALL: stall_d = 1'b1;
               default: ;
            endcase
         end

         FC_SLEEP: begin
            // Any pending interrupt wakes the core; only an enabled one redirects.
            if (dbg_req_i) begin
               pc_set_d     = 1'b1;
               pc_sel_mux_d = PC_EXC;
               exc_sel_d    = EXC_PC_DBD;
               debug_d      = 1'b1;
               redirect     = 1'b1;
            end else if (irq_req_i && irq_en_i) begin
               pc_set_d     = 1'b1;
               pc_sel_mux_d = PC_EXC;
               exc_sel_d    = EXC_PC_IRQ;
               redirect     = 1'b1;
            end else if (irq_req_i) begin
               pc_set_d = 1'b1;
               state_d  = FC_RUN;
            end else begin
               stall_d    = 1'b1;
               sleeping_d = 1'b1;
            end
         end

         default: state_d = FC_RESET;
      endcase

      if (redirect) begin
         state_d     = FC_FLUSH;
         flush_cnt_d = FLUSH_CNT_W'(FLUSH_CYCLES);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= FC_RESET;
         boot_cnt_q   <= '0;
         flush_cnt_q  <= '0;
         debug_mode_o <= 1'b0;
         pc_sel_mux_o <= PC_NEXT;
         exc_sel_o    <= EXC_PC_EXC;
         pc_sel_o     <= 1'b0;
         pc_set_o     <= 1'b0;
         flush_o      <= 1'b0;
         stall_o      <= 1'b0;
         sleeping_o   <= 1'b0;
      end else begin
         state_q      <= state_d;
         boot_cnt_q   <= boot_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
         debug_mode_o <= debug_d;
         pc_sel_mux_o <= pc_sel_mux_d;
         exc_sel_o    <= exc_sel_d;
         pc_sel_o     <= pc_sel_d;
         pc_set_o     <= pc_set_d;
         flush_o      <= flush_d;
         stall_o      <= stall_d;
         sleeping_o   <= sleeping_d;
      end
   end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios then randomized traffic, all
// compared each cycle against a flag-based behavioural model.
module tb_if_fetch_ctrl;
   import if_fetch_ctrl_pkg::*;

   localparam int unsigned BOOT_DELAY   = 4;
   localparam int unsigned FLUSH_CYCLES = 2;

   logic clk, rst_n;
   logic fetch_enable, stall_req, branch_taken, exc_req, irq_req, irq_en;
   logic dbg_req, mret, dret, wfi;
   pc_sel_e     pc_sel_mux;
   exc_pc_sel_e exc_sel;
   logic pc_sel, pc_set, flush, stall, debug_mode, sleeping;

   int n_vec, n_err;
   string ph;

   // Model: progress flags instead of a state variable.
   bit m_in_reset, m_boot, m_sleep, m_dbg;
   int m_since, m_flush;
   pc_sel_e     e_mux;
   exc_pc_sel_e e_exc;
   bit e_pc_sel, e_pc_set, e_flush, e_stall, e_sleep;

   if_fetch_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .BOOT_DELAY(BOOT_DELAY)) dut (
      .clk(clk), .rst_n(rst_n),
      .fetch_enable_i(fetch_enable), .stall_req_i(stall_req),
      .branch_taken_i(branch_taken), .exc_req_i(exc_req),
      .irq_req_i(irq_req), .irq_en_i(irq_en), .dbg_req_i(dbg_req),
      .mret_i(mret), .dret_i(dret), .wfi_i(wfi),
      .pc_sel_mux_o(pc_sel_mux), .exc_sel_o(exc_sel), .pc_sel_o(pc_sel),
      .pc_set_o(pc_set), .flush_o(flush), .stall_o(stall),
      .debug_mode_o(debug_mode), .sleeping_o(sleeping)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_in_reset = 1'b1; m_boot = 1'b0; m_sleep = 1'b0; m_dbg = 1'b0;
      m_since = 0; m_flush = 0;
      e_mux = PC_NEXT; e_exc = EXC_PC_EXC;
      e_pc_sel = 1'b0; e_pc_set = 1'b0; e_flush = 1'b0; e_stall = 1'b0; e_sleep = 1'b0;
   endtask

   task automatic take(input pc_sel_e pc, input exc_pc_sel_e ev);
      e_mux = pc; e_exc = ev; e_pc_set = 1'b1; m_flush = FLUSH_CYCLES;
   endtask

   task automatic model_step();
      e_mux = PC_NEXT; e_exc = EXC_PC_EXC;
      e_pc_sel = 1'b0; e_pc_set = 1'b0; e_flush = 1'b0; e_stall = 1'b0; e_sleep = 1'b0;
      if (m_in_reset) begin
         if (m_since >= BOOT_DELAY && fetch_enable) begin
            m_in_reset = 1'b0;
            m_boot     = 1'b1;
         end
         m_since++;
      end else if (m_boot) begin
         e_mux = PC_BP; m_boot = 1'b0; m_flush = FLUSH_CYCLES;
      end else if (m_flush > 0) begin
         e_flush = 1'b1; m_flush--;
      end else if (m_sleep) begin
         if (dbg_req) begin
            m_sleep = 1'b0; m_dbg = 1'b1; take(PC_EXC, EXC_PC_DBD);
         end else if (irq_req && irq_en) begin
            m_sleep = 1'b0; take(PC_EXC, EXC_PC_IRQ);
         end else if (irq_req) begin
            m_sleep = 1'b0; e_pc_set = 1'b1;
         end else begin
            e_stall = 1'b1; e_sleep = 1'b1;
         end
      end else begin
         e_pc_set = 1'b1;
         if (dbg_req && !m_dbg) begin
            m_dbg = 1'b1; take(PC_EXC, EXC_PC_DBD);
         end else if (exc_req) take(PC_EXC, m_dbg ? EXC_PC_DBG_EXC : EXC_PC_EXC);
         else if (irq_req && irq_en && !m_dbg) take(PC_EXC, EXC_PC_IRQ);
         else if (dret && m_dbg) begin
            m_dbg = 1'b0; take(PC_DRET, EXC_PC_EXC);
         end else if (mret) take(PC_ERET, EXC_PC_EXC);
         else if (branch_taken) begin
            e_pc_sel = 1'b1; m_flush = FLUSH_CYCLES;
         end else if (wfi && !m_dbg) begin
            m_sleep = 1'b1; e_pc_set = 1'b0; e_stall = 1'b1; e_sleep = 1'b1;
         end else if (stall_req) e_stall = 1'b1;
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".pc_sel_mux"}, int'(pc_sel_mux), int'(e_mux));
      chk({tag, ".exc_sel"},    int'(exc_sel),    int'(e_exc));
      chk({tag, ".pc_sel"},     int'(pc_sel),     int'(e_pc_sel));
      chk({tag, ".pc_set"},     int'(pc_set),     int'(e_pc_set));
      chk({tag, ".flush"},      int'(flush),      int'(e_flush));
      chk({tag, ".stall"},      int'(stall),      int'(e_stall));
      chk({tag, ".debug_mode"}, int'(debug_mode), int'(m_dbg));
      chk({tag, ".sleeping"},   int'(sleeping),   int'(e_sleep));
   endtask

   task automatic clear_inputs();
      stall_req = 1'b0; branch_taken = 1'b0; exc_req = 1'b0; irq_req = 1'b0;
      irq_en = 1'b0; dbg_req = 1'b0; mret = 1'b0; dret = 1'b0; wfi = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1 check_outputs(ph);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Called 1ns after an edge: pull reset mid-cycle, hold it over one edge.
   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_outputs({ph, ".arst"});
      @(posedge clk);
      #1 check_outputs({ph, ".arst_hold"});
      rst_n = 1'b1;
   endtask

   task automatic boot_to_run();
      clear_inputs();
      fetch_enable = 1'b1;
      ticks(BOOT_DELAY + 2 + FLUSH_CYCLES + 1);
   endtask

   initial begin
      n_vec = 0; n_err = 0; ph = "por";
      clear_inputs();
      fetch_enable = 1'b0;
      model_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2 check_outputs(ph);
      #9 rst_n = 1'b1;

      ph = "boot";
      fetch_enable = 1'b1;
      ticks(BOOT_DELAY + 2);
      chk("boot_pc_bp", int'(pc_sel_mux), int'(PC_BP));
      tick(); chk("boot_flush1", int'(flush), 1);
      tick(); chk("boot_flush2", int'(flush), 1);
      tick(); chk("boot_run_pc_set", int'(pc_set), 1);
      chk("boot_run_flush", int'(flush), 0);

      ph = "multi_req";
      exc_req = 1'b1; irq_req = 1'b1; mret = 1'b1; irq_en = 1'b1;
      tick();
      chk("multi_exc", int'(exc_sel), int'(EXC_PC_EXC));
      chk("multi_mux", int'(pc_sel_mux), int'(PC_EXC));
      exc_req = 1'b0; mret = 1'b0;
      ticks(FLUSH_CYCLES + 1);
      chk("held_irq", int'(exc_sel), int'(EXC_PC_IRQ));
      irq_req = 1'b0; irq_en = 1'b0;
      ticks(FLUSH_CYCLES + 1);

      ph = "debug";
      dbg_req = 1'b1; tick();
      chk("dbg_enter_vec", int'(exc_sel), int'(EXC_PC_DBD));
      chk("dbg_enter_mode", int'(debug_mode), 1);
      dbg_req = 1'b0; ticks(FLUSH_CYCLES);
      exc_req = 1'b1; tick();
      chk("dbg_exc_vec", int'(exc_sel), int'(EXC_PC_DBG_EXC));
      exc_req = 1'b0; ticks(FLUSH_CYCLES);
      wfi = 1'b1; tick(); wfi = 1'b0;
      dret = 1'b1; tick();
      chk("dret_mux", int'(pc_sel_mux), int'(PC_DRET));
      chk("dret_mode", int'(debug_mode), 0);
      dret = 1'b0; ticks(FLUSH_CYCLES + 1);

      ph = "wfi";
      wfi = 1'b1; tick();
      chk("wfi_sleep", int'(sleeping), 1);
      chk("wfi_stall", int'(stall), 1);
      wfi = 1'b0; ticks(3);
      irq_req = 1'b1; irq_en = 1'b0; tick();
      chk("wake_noen_mux", int'(pc_sel_mux), int'(PC_NEXT));
      chk("wake_noen_sleep", int'(sleeping), 0);
      irq_req = 1'b0;
      wfi = 1'b1; tick(); wfi = 1'b0; ticks(2);
      irq_req = 1'b1; irq_en = 1'b1; tick();
      chk("wake_irq_vec", int'(exc_sel), int'(EXC_PC_IRQ));
      irq_req = 1'b0; irq_en = 1'b0;
      ticks(FLUSH_CYCLES + 1);

      ph = "stall_branch";
      stall_req = 1'b1; tick();
      chk("stall_1", int'(stall), 1);
      branch_taken = 1'b1; tick();
      chk("stall_2", int'(stall), 0);
      chk("branch_pc_sel", int'(pc_sel), 1);
      branch_taken = 1'b0; tick();
      chk("branch_flush1", int'(flush), 1);
      stall_req = 1'b0; tick();
      chk("branch_flush2", int'(flush), 1);
      tick();

      ph = "rst_flush";
      mret = 1'b1; tick(); mret = 1'b0; tick();
      async_reset();
      boot_to_run();
      ph = "rst_debug";
      dbg_req = 1'b1; tick(); dbg_req = 1'b0; ticks(FLUSH_CYCLES + 2);
      async_reset();
      boot_to_run();

      ph = "random";
      for (int c = 0; c < 4000; c++) begin
         fetch_enable = ($urandom_range(0, 99) < 70);
         dbg_req      = ($urandom_range(0, 99) < 3);
         exc_req      = ($urandom_range(0, 99) < 5);
         irq_req      = ($urandom_range(0, 99) < 8);
         irq_en       = ($urandom_range(0, 99) < 50);
         mret         = ($urandom_range(0, 99) < 5);
         dret         = ($urandom_range(0, 99) < 8);
         wfi          = ($urandom_range(0, 99) < 6);
         branch_taken = ($urandom_range(0, 99) < 10);
         stall_req    = ($urandom_range(0, 99) < 25);
         tick();
         if ($urandom_range(0, 399) == 0) async_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
